// File: rtl/sb_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
// Build option: define SB_STALL_CNT_EN to add the stall_cycles counter port.
package sb_pkg;

    localparam int unsigned SB_NREG = 32;
    localparam int unsigned SB_AW   = 5;
    localparam int unsigned SB_CW   = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_TMO   = 2'd2
    } sb_state_e;

    // In-flight count seen by decode: a same-cycle writeback already retires one write.
    function automatic logic [31:0] sb_eff_cnt(input logic [31:0] pend, input logic wb_hit);
        return pend - ((wb_hit && (pend != 32'd0)) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/sb_pend_counter.sv
// Per-register pending-write counter: saturating up/down with clear and underflow flag.
module sb_pend_counter
    import sb_pkg::*;
#(
    parameter int unsigned CW = SB_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          underflow_c
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          dec_ok;

    // Next count: clear wins, simultaneous inc/dec cancel, dec at zero is dropped.
    always_comb begin
        cnt_d       = cnt_q;
        dec_ok      = dec && (cnt_q != '0);
        underflow_c = dec && !clr && (cnt_q == '0);
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec_ok) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec_ok && !inc) begin
            cnt_d = cnt_q - CW'(1);
        end
        busy_d = (cnt_d != '0);
    end

    // Count and busy flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign count = cnt_q;
    assign busy  = busy_q;

endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// Register-hazard scheduler between decode and the register file.
// Tracks in-flight writes per register, gates issue, drives stall/bubble,
// runs a stall watchdog. Define SB_STALL_CNT_EN to add the stall_cycles counter.
module reg_scoreboard_ctrl
    import sb_pkg::*;
#(
    parameter int unsigned NREG          = SB_NREG,
    parameter int unsigned AW            = SB_AW,
    parameter int unsigned CW            = SB_CW,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_addr,
    output logic            id_ready,
    output logic            issue,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec,
    output logic            hazard_timeout,
    output logic            wb_underflow
`ifdef SB_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int unsigned TW = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0]   pend [NREG];
    logic [NREG-1:0] busy_w;
    logic [NREG-1:0] uf_w;

    sb_state_e state_q, state_d;
    logic [TW-1:0] scnt_q, scnt_d;
    logic          tmo_q, tmo_d;
    logic          uf_q, uf_d;
    logic          rs_haz, rt_haz, wr_haz, hazard;

    // Register 0 is hard-wired zero and never tracked.
    assign pend[0]   = '0;
    assign busy_w[0] = 1'b0;
    assign uf_w[0]   = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_pend
        logic inc, dec;
        assign inc = issue && id_wr_en && (id_wr_addr == AW'(r));
        assign dec = wb_valid && (wb_addr == AW'(r));
        sb_pend_counter #(.CW(CW)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .inc         (inc),
            .dec         (dec),
            .clr         (flush),
            .count       (pend[r]),
            .busy        (busy_w[r]),
            .underflow_c (uf_w[r])
        );
    end

    // Hazard compare and zero-latency issue decision.
    always_comb begin
        rs_haz = id_rs_used && (id_rs != '0) &&
                 (sb_eff_cnt(32'(pend[id_rs]), wb_valid && (wb_addr == id_rs)) != 32'd0);
        rt_haz = id_rt_used && (id_rt != '0) &&
                 (sb_eff_cnt(32'(pend[id_rt]), wb_valid && (wb_addr == id_rt)) != 32'd0);
        // A same-cycle writeback to the destination frees one slot.
        wr_haz = id_wr_en && (id_wr_addr != '0) &&
                 (sb_eff_cnt(32'(pend[id_wr_addr]), wb_valid && (wb_addr == id_wr_addr))
                  == 32'(CNT_MAX));
        hazard    = rs_haz || rt_haz || wr_haz;
        id_ready  = !reset && !flush && (state_q != ST_TMO) && !hazard;
        issue     = id_valid && id_ready;
        stall_if  = id_valid && !id_ready;
        stall_id  = stall_if;
        bubble_ex = stall_if;
    end

    // FSM next state, consecutive-stall watchdog and sticky flags.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        tmo_d   = tmo_q;
        uf_d    = uf_q || (|uf_w);
        if (flush) begin
            state_d = ST_RUN;
            scnt_d  = '0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (id_valid && hazard) begin
                        state_d = ST_STALL;
                        scnt_d  = TW'(1);
                    end
                end
                ST_STALL: begin
                    if (!stall_if) begin
                        state_d = ST_RUN;
                        scnt_d  = '0;
                    end else if (scnt_q == TW'(STALL_TIMEOUT - 1)) begin
                        state_d = ST_TMO;
                        tmo_d   = 1'b1;
                    end else begin
                        scnt_d = scnt_q + TW'(1);
                    end
                end
                ST_TMO: begin
                    state_d = ST_TMO;
                end
                default: begin
                    state_d = ST_RUN;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    // FSM and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            scnt_q  <= '0;
            tmo_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            tmo_q   <= tmo_d;
            uf_q    <= uf_d;
        end
    end

    assign busy_vec       = busy_w;
    assign hazard_timeout = tmo_q;
    assign wb_underflow   = uf_q;

`ifdef SB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Total stall cycles, wraps naturally; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
